// File: rtl/mod11_bist.sv
// Self-checking stimulus driver for a mod-M adder/subtractor: sweeps every
// (s, x, y) vector, compares z with an internal golden residue, and keeps counts.
module mod11_bist #(
  parameter int unsigned MODULUS = 11,
  parameter int unsigned SETTLE  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] z,
  output logic       s,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic       busy,
  output logic       done,
  output logic [7:0] pass_cnt,
  output logic [7:0] fail_cnt,
  output logic       ff_valid,
  output logic       ff_s,
  output logic [3:0] ff_x,
  output logic [3:0] ff_y,
  output logic [3:0] ff_z
);

  localparam int unsigned OPW = 4;
  localparam int unsigned CNTW = 8;
  localparam logic [OPW-1:0] LAST_OP = OPW'(MODULUS - 1);
  localparam logic [OPW-1:0] SETTLE_LAST = OPW'(SETTLE - 1);
  localparam logic [OPW:0] MOD_W = (OPW + 1)'(MODULUS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [OPW-1:0]  settle_q, settle_d;
  logic            s_q, s_d;
  logic [OPW-1:0]  x_q, x_d, y_q, y_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [CNTW-1:0] pass_q, pass_d, fail_q, fail_d;
  logic            ffv_q, ffv_d, ffs_q, ffs_d;
  logic [OPW-1:0]  ffx_q, ffx_d, ffy_q, ffy_d, ffz_q, ffz_d;

  logic [OPW:0]    sum_c, diff_c;
  logic [OPW-1:0]  gold_c;

  // Golden residue for the vector currently on s/x/y; never negative.
  always_comb begin
    sum_c = {1'b0, x_q} + {1'b0, y_q};
    if (x_q >= y_q) diff_c = {1'b0, x_q} - {1'b0, y_q};
    else            diff_c = {1'b0, x_q} + MOD_W - {1'b0, y_q};
    if (s_q)                 gold_c = OPW'(diff_c);
    else if (sum_c >= MOD_W) gold_c = OPW'(sum_c - MOD_W);
    else                     gold_c = OPW'(sum_c);
  end

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    s_d      = s_q;
    x_d      = x_q;
    y_d      = y_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    ffv_d    = ffv_q;
    ffs_d    = ffs_q;
    ffx_d    = ffx_q;
    ffy_d    = ffy_q;
    ffz_d    = ffz_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_DRIVE;
          settle_d = '0;
          s_d      = 1'b0;
          x_d      = '0;
          y_d      = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = '0;
          fail_d   = '0;
          ffv_d    = 1'b0;
          ffs_d    = 1'b0;
          ffx_d    = '0;
          ffy_d    = '0;
          ffz_d    = '0;
        end
      end

      ST_DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = ST_CHECK;
        end else begin
          settle_d = settle_q + OPW'(1);
        end
      end

      ST_CHECK: begin
        if (z == gold_c) begin
          pass_d = pass_q + CNTW'(1);
        end else begin
          fail_d = fail_q + CNTW'(1);
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffs_d = s_q;
            ffx_d = x_q;
            ffy_d = y_q;
            ffz_d = z;
          end
        end
        state_d = ST_DRIVE;
        // y innermost, then x, then s; wrapping past s=1 ends the sweep.
        if (y_q != LAST_OP) begin
          y_d = y_q + OPW'(1);
        end else begin
          y_d = '0;
          if (x_q != LAST_OP) begin
            x_d = x_q + OPW'(1);
          end else begin
            x_d = '0;
            if (!s_q) begin
              s_d = 1'b1;
            end else begin
              s_d     = 1'b0;
              state_d = ST_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      s_q      <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= '0;
      fail_q   <= '0;
      ffv_q    <= 1'b0;
      ffs_q    <= 1'b0;
      ffx_q    <= '0;
      ffy_q    <= '0;
      ffz_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      s_q      <= s_d;
      x_q      <= x_d;
      y_q      <= y_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      ffv_q    <= ffv_d;
      ffs_q    <= ffs_d;
      ffx_q    <= ffx_d;
      ffy_q    <= ffy_d;
      ffz_q    <= ffz_d;
    end
  end

  assign s        = s_q;
  assign x        = x_q;
  assign y        = y_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign ff_valid = ffv_q;
  assign ff_s     = ffs_q;
  assign ff_x     = ffx_q;
  assign ff_y     = ffy_q;
  assign ff_z     = ffz_q;

endmodule

// File: tb/tb_mod11_bist.sv
// Bench for mod11_bist: behavioural adders (correct and faulty) answer the
// BIST's vectors; sweep results are compared with hand-computed constants.
module tb_mod11_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, start7;
  int         mode;
  logic [3:0] z, z7;
  logic       s, s7, busy, busy7, done, done7;
  logic [3:0] x, y, x7, y7;
  logic [7:0] pass_cnt, fail_cnt, pass7, fail7;
  logic       ff_valid, ff_s, ffv7, ffs7;
  logic [3:0] ff_x, ff_y, ff_z, ffx7, ffy7, ffz7;

  int checks = 0;
  int errors = 0;

  mod11_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start), .z(z),
    .s(s), .x(x), .y(y), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .ff_valid(ff_valid),
    .ff_s(ff_s), .ff_x(ff_x), .ff_y(ff_y), .ff_z(ff_z)
  );

  mod11_bist #(.MODULUS(7), .SETTLE(3)) dut7 (
    .clk(clk), .rst_n(rst_n), .start(start7), .z(z7),
    .s(s7), .x(x7), .y(y7), .busy(busy7), .done(done7),
    .pass_cnt(pass7), .fail_cnt(fail7), .ff_valid(ffv7),
    .ff_s(ffs7), .ff_x(ffx7), .ff_y(ffy7), .ff_z(ffz7)
  );

  // Adder under test. mode 0: correct, 1: z0 stuck at 0, 2: subtract without +M fix-up.
  function automatic logic [3:0] adder(input int md, input logic op, input logic [3:0] a,
                                       input logic [3:0] b, input int m);
    int r;
    if (!op) begin
      r = int'(a) + int'(b);
      if (r >= m) r = r - m;
    end else begin
      r = int'(a) - int'(b);
      if (md != 2 && r < 0) r = r + m;
    end
    adder = 4'(r);
    if (md == 1) adder[0] = 1'b0;
  endfunction

  always_comb z  = adder(mode, s, x, y, 11);
  always_comb z7 = adder(0, s7, x7, y7, 7);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, optionally pulse it again at busy cycle restart_at, count busy cycles.
  task automatic run_sweep(input int md, input int restart_at, output int cyc);
    mode  = md;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("done_after_start", int'(done), 0);
    cyc = 0;
    while (busy && cyc < 2000) begin
      cyc++;
      start = (cyc == restart_at);
      tick();
    end
    start = 1'b0;
  endtask

  typedef struct {
    int mode;
    int busy_cyc;
    int pass_e;
    int fail_e;
    int ffv_e;
    int ffs_e;
    int ffx_e;
    int ffy_e;
    int ffz_e;
  } vec_t;

  vec_t tbl[4];
  int   cyc;

  initial begin
    tbl[0] = '{0, 484, 242,   0, 0, 0, 0, 0,  0};
    tbl[1] = '{1, 484, 132, 110, 1, 0, 0, 1,  0};
    tbl[2] = '{2, 484, 187,  55, 1, 1, 0, 1, 15};
    tbl[3] = '{0, 484, 242,   0, 0, 0, 0, 0,  0};

    rst_n = 1'b0; start = 1'b0; start7 = 1'b0; mode = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass_cnt), 0);
    chk("rst_sxy", int'({s, x, y}), 0);
    chk("rst_ffv", int'(ff_valid), 0);

    // Back-to-back sweeps: each new start lands in the first DONE cycle.
    foreach (tbl[i]) begin
      run_sweep(tbl[i].mode, -1, cyc);
      chk($sformatf("v%0d_busy_cycles", i), cyc, tbl[i].busy_cyc);
      chk($sformatf("v%0d_done", i), int'(done), 1);
      chk($sformatf("v%0d_pass", i), int'(pass_cnt), tbl[i].pass_e);
      chk($sformatf("v%0d_fail", i), int'(fail_cnt), tbl[i].fail_e);
      chk($sformatf("v%0d_ffv", i), int'(ff_valid), tbl[i].ffv_e);
      chk($sformatf("v%0d_ffs", i), int'(ff_s), tbl[i].ffs_e);
      chk($sformatf("v%0d_ffx", i), int'(ff_x), tbl[i].ffx_e);
      chk($sformatf("v%0d_ffy", i), int'(ff_y), tbl[i].ffy_e);
      chk($sformatf("v%0d_ffz", i), int'(ff_z), tbl[i].ffz_e);
      chk($sformatf("v%0d_sxy_idle", i), int'({s, x, y}), 0);
    end

    // Results hold in DONE while start stays low.
    repeat (5) tick();
    chk("hold_done", int'(done), 1);
    chk("hold_pass", int'(pass_cnt), 242);

    // Mid-sweep reset at sweep cycle 200.
    mode  = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (199) tick();
    chk("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_pass", int'(pass_cnt), 0);
    chk("midrst_fail", int'(fail_cnt), 0);
    chk("midrst_ffv", int'(ff_valid), 0);
    chk("midrst_sxy", int'({s, x, y}), 0);
    tick();
    run_sweep(0, -1, cyc);
    chk("after_rst_cycles", cyc, 484);
    chk("after_rst_pass", int'(pass_cnt), 242);

    // Second start at sweep cycle 100 must be ignored.
    run_sweep(0, 100, cyc);
    chk("restart_cycles", cyc, 484);
    chk("restart_pass", int'(pass_cnt), 242);
    chk("restart_fail", int'(fail_cnt), 0);
    chk("restart_done", int'(done), 1);

    // MODULUS=7, SETTLE=3 instance.
    start7 = 1'b1;
    tick();
    start7 = 1'b0;
    chk("m7_busy_start", int'(busy7), 1);
    cyc = 0;
    while (busy7 && cyc < 2000) begin
      cyc++;
      tick();
    end
    chk("m7_busy_cycles", cyc, 392);
    chk("m7_done", int'(done7), 1);
    chk("m7_pass", int'(pass7), 98);
    chk("m7_fail", int'(fail7), 0);
    chk("m7_ffv", int'(ffv7), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
